sdram_port_arbiter: RTL and testbench

- N-channel arbiter in front of the single 8-bit sdram controller port; replaces the hand-written combinational download/eraser/cpu mux in the top level.
- Grants one channel per SDRAM slot. A slot starts on a strobe aligned to the controller's clkref.
- Holds address, data and command stable for the whole slot and returns read data with a req/ack handshake.
- Channel 0 has the highest fixed priority (downloader), then eraser, then cpu.

---
 rtl/sdram_port_arbiter_if.sv | 34 +++
 rtl/sdram_port_arbiter.sv | 127 ++++++++++++
 tb/tb_sdram_port_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/sdram_port_arbiter_if.sv
// Channel-side and sdram-side signal bundle for the sdram port arbiter.
// The arbiter takes the slave view; requesters, the controller and benches take the master view.
interface sdram_port_arbiter_if #(
    parameter int NCH = 3,
    parameter int AW  = 25,
    parameter int DW  = 8
);
    logic              slot_stb;
    logic [NCH-1:0]    ch_req;
    logic [NCH-1:0]    ch_we;
    logic [NCH*AW-1:0] ch_addr;
    logic [NCH*DW-1:0] ch_din;
    logic [NCH-1:0]    ch_ack;
    logic [DW-1:0]     ch_dout;
    logic [NCH-1:0]    grant;
    logic [AW-1:0]     sdram_addr;
    logic [DW-1:0]     sdram_din;
    logic              sdram_we;
    logic              sdram_oe;
    logic [DW-1:0]     sdram_dout;
    logic              overrun;

    modport slave (
        input  slot_stb, ch_req, ch_we, ch_addr, ch_din, sdram_dout,
        output ch_ack, ch_dout, grant, sdram_addr, sdram_din,
        output sdram_we, sdram_oe, overrun
    );

    modport master (
        output slot_stb, ch_req, ch_we, ch_addr, ch_din, sdram_dout,
        input  ch_ack, ch_dout, grant, sdram_addr, sdram_din,
        input  sdram_we, sdram_oe, overrun
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Slot-based N-channel arbiter for the single 8-bit sdram controller port.
// Define ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority (ch0 first).
module sdram_port_arbiter #(
    parameter int NCH    = 3,
    parameter int AW     = 25,
    parameter int DW     = 8,
    parameter int RD_LAT = 5
) (
    input logic                sys_clock,
    input logic                res_n,
    sdram_port_arbiter_if.slave bus
);
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW = $clog2(RD_LAT + 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt;
    logic [NCH-1:0]  grant_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   din_q;
    logic            we_q;
    logic            oe_q;
    logic [DW-1:0]   dout_q;
    logic            ovr_q;
    logic [IW-1:0]   win;
    logic            start;
    logic            done;

`ifdef ARB_ROUND_ROBIN_EN
    logic [IW-1:0]   ptr_q;
`endif

    assign start = (state == IDLE) && bus.slot_stb && (|bus.ch_req);
    assign done  = (state == ACCESS) && (cnt == CW'(RD_LAT));

    // Scan so the highest-priority candidate is assigned last and wins.
    always_comb begin
        int j;
        j   = 0;
        win = '0;
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = NCH; k >= 1; k--) begin
            j = int'(ptr_q) + k;
            if (j >= NCH) j = j - NCH;
            if (bus.ch_req[j]) win = IW'(j);
        end
`else
        for (int i = NCH - 1; i >= 0; i--) begin
            if (bus.ch_req[i]) win = IW'(i);
        end
        j = int'(win);
`endif
    end

    always_ff @(posedge sys_clock or negedge res_n) begin
        if (!res_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = ACCESS;
            ACCESS:  if (done)  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Read data is bypassed in the ack cycle so it arrives together with ack.
    always_comb begin
        bus.ch_ack  = '0;
        bus.ch_dout = dout_q;
        if (done) begin
            bus.ch_ack = grant_q;
            if (oe_q) bus.ch_dout = bus.sdram_dout;
        end
    end

    assign bus.grant      = grant_q;
    assign bus.sdram_addr = addr_q;
    assign bus.sdram_din  = din_q;
    assign bus.sdram_we   = we_q;
    assign bus.sdram_oe   = oe_q;
    assign bus.overrun    = ovr_q;

    always_ff @(posedge sys_clock or negedge res_n) begin
        if (!res_n) begin
            cnt     <= '0;
            grant_q <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            we_q    <= 1'b0;
            oe_q    <= 1'b0;
            dout_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            if (start) begin
                cnt     <= CW'(1);
                grant_q <= NCH'(1) << win;
                addr_q  <= bus.ch_addr[int'(win)*AW +: AW];
                din_q   <= bus.ch_din[int'(win)*DW +: DW];
                we_q    <= bus.ch_we[win];
                oe_q    <= ~bus.ch_we[win];
            end else if (state == ACCESS) begin
                if (done) begin
                    cnt     <= '0;
                    grant_q <= '0;
                    we_q    <= 1'b0;
                    oe_q    <= 1'b0;
                    if (oe_q) dout_q <= bus.sdram_dout;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
            if ((state == ACCESS) && bus.slot_stb) ovr_q <= 1'b1;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge sys_clock or negedge res_n) begin
        if (!res_n)     ptr_q <= IW'(NCH - 1);
        else if (start) ptr_q <= win;
    end
`endif
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter (NCH=3, RD_LAT=5).
// Inputs change and outputs are sampled on the falling edge.
module tb_sdram_port_arbiter;
    localparam int NCH    = 3;
    localparam int AW     = 25;
    localparam int DW     = 8;
    localparam int RD_LAT = 5;

    logic sys_clock = 1'b0;
    logic res_n     = 1'b0;
    int   total     = 0;
    int   bad       = 0;

    sdram_port_arbiter_if #(.NCH(NCH), .AW(AW), .DW(DW)) bus ();

    sdram_port_arbiter #(
        .NCH(NCH), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)
    ) dut (
        .sys_clock (sys_clock),
        .res_n     (res_n),
        .bus       (bus)
    );

    always #5 sys_clock = ~sys_clock;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic strobe();
        bus.slot_stb = 1'b1;
        @(negedge sys_clock);
        bus.slot_stb = 1'b0;
    endtask

    // One slot: strobe, check grant at +1, ack at +RD_LAT, idle at +RD_LAT+1.
    task automatic run_slot(string tag, logic [2:0] exp_g, logic drop);
        strobe();
        check({tag, "_grant"}, 64'(bus.grant), 64'(exp_g));
        repeat (RD_LAT - 1) @(negedge sys_clock);
        check({tag, "_ack"}, 64'(bus.ch_ack), 64'(exp_g));
        if (drop) bus.ch_req = bus.ch_req & ~exp_g;
        @(negedge sys_clock);
        check({tag, "_gnt0"}, 64'(bus.grant), 64'(0));
    endtask

    initial begin
        logic [2:0] rr_exp [4];
        bus.slot_stb   = 1'b0;
        bus.ch_req     = '0;
        bus.ch_we      = '0;
        bus.ch_addr    = '0;
        bus.ch_din     = '0;
        bus.sdram_dout = '0;
        repeat (2) @(negedge sys_clock);
        check("rst_grant", 64'(bus.grant), 64'(0));
        check("rst_ack", 64'(bus.ch_ack), 64'(0));
        check("rst_weoe", 64'({bus.sdram_we, bus.sdram_oe}), 64'(0));
        check("rst_dout", 64'(bus.ch_dout), 64'(0));
        check("rst_ovr", 64'(bus.overrun), 64'(0));
        res_n = 1'b1;
        @(negedge sys_clock);

        // conflict: ch0 and ch2 both reading
        bus.ch_req = 3'b101;
        run_slot("cf0", 3'b001, 1'b1);
        run_slot("cf1", 3'b100, 1'b1);

        // all three held across four slots
`ifdef ARB_ROUND_ROBIN_EN
        rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
`else
        rr_exp = '{3'b001, 3'b001, 3'b001, 3'b001};
`endif
        bus.ch_req = 3'b111;
        for (int s = 0; s < 4; s++) run_slot("hold", rr_exp[s], 1'b0);
        bus.ch_req = 3'b000;

        // read by ch2
        bus.ch_we = 3'b000;
        bus.ch_addr[2*AW +: AW] = 25'h10005;
        bus.sdram_dout = 8'hA5;
        bus.ch_req = 3'b100;
        strobe();
        check("rd_grant", 64'(bus.grant), 64'(3'b100));
        check("rd_oe", 64'({bus.sdram_oe, bus.sdram_we}), 64'(2'b10));
        check("rd_addr", 64'(bus.sdram_addr), 64'h10005);
        check("rd_ack_early", 64'(bus.ch_ack), 64'(0));
        repeat (RD_LAT - 1) @(negedge sys_clock);
        check("rd_ack", 64'(bus.ch_ack), 64'(3'b100));
        check("rd_dout", 64'(bus.ch_dout), 64'hA5);
        bus.ch_req = 3'b000;
        @(negedge sys_clock);
        bus.sdram_dout = 8'h11;
        #1;
        check("rd_gnt0", 64'(bus.grant), 64'(0));
        check("rd_oe0", 64'(bus.sdram_oe), 64'(0));
        check("rd_hold", 64'(bus.ch_dout), 64'hA5);

        // write 0x3C to 0x00123 by ch1
        bus.ch_we = 3'b010;
        bus.ch_addr[1*AW +: AW] = 25'h00123;
        bus.ch_din[1*DW +: DW] = 8'h3C;
        bus.ch_req = 3'b010;
        strobe();
        for (int c = 1; c <= RD_LAT; c++) begin
            check("wr_bus", {bus.sdram_we, bus.sdram_oe, 7'(bus.sdram_addr), bus.sdram_din},
                  {1'b1, 1'b0, 7'h23, 8'h3C});
            check("wr_ack", 64'(bus.ch_ack), (c == RD_LAT) ? 64'(3'b010) : 64'(0));
            if (c == RD_LAT) bus.ch_req = 3'b000;
            @(negedge sys_clock);
        end
        check("wr_end", 64'({bus.grant, bus.sdram_we}), 64'(0));
        check("wr_dout", 64'(bus.ch_dout), 64'hA5);
        check("wr_addr", 64'(bus.sdram_addr), 64'h00123);
        bus.ch_we = 3'b000;

        // idle slots
        for (int s = 0; s < 10; s++) begin
            strobe();
            @(negedge sys_clock);
            check("idle", 64'({bus.grant, bus.ch_ack, bus.sdram_we, bus.sdram_oe}), 64'(0));
        end
        check("idle_ovr", 64'(bus.overrun), 64'(0));

        // overrun: second strobe three cycles later
        bus.ch_req = 3'b001;
        strobe();
        @(negedge sys_clock);
        bus.ch_req = 3'b011;
        @(negedge sys_clock);
        strobe();
        check("ovr_flag", 64'(bus.overrun), 64'(1));
        check("ovr_grant", 64'(bus.grant), 64'(3'b001));
        @(negedge sys_clock);
        check("ovr_ack", 64'(bus.ch_ack), 64'(3'b001));
        bus.ch_req = 3'b000;
        @(negedge sys_clock);
        check("ovr_end", 64'({bus.grant, bus.overrun}), 64'(1));

        // reset in the middle of an access
        bus.ch_req = 3'b010;
        strobe();
        @(negedge sys_clock);
        res_n = 1'b0;
        #1;
        check("mrst_out", 64'({bus.grant, bus.ch_ack, bus.sdram_we, bus.sdram_oe}), 64'(0));
        check("mrst_addr", 64'(bus.sdram_addr), 64'(0));
        check("mrst_ovr", 64'(bus.overrun), 64'(0));
        check("mrst_dout", 64'(bus.ch_dout), 64'(0));
        @(negedge sys_clock);
        res_n = 1'b1;
        repeat (4) @(negedge sys_clock);
        check("mrst_noack", 64'({bus.ch_ack, bus.grant}), 64'(0));
        run_slot("post", 3'b010, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
